// File: rtl/sand_ctrl_pkg.sv
// Shared types and helpers for the sandpile step scheduler and the array bench.
//   sched_state_t : scheduler FSM states
//   COORD_W       : width of a grid coordinate / resolution value
//   sanitize_res  : clamp a requested resolution to the grid, snapped to whole tiles
//   step_budget   : cycles one relaxation step occupies at a given resolution
package sand_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} sched_state_t;

  localparam int COORD_W = 9;

  // Resolution must cover whole inner-engine tiles and never exceed the grid.
  function automatic int sanitize_res(input int cfg,
                                      input int rows       = 32,
                                      input int cols       = 32,
                                      input int cols_small = 4);
    int r;
    r = cfg;
    if (r > rows) r = rows;
    if (r > cols) r = cols;
    r = r - (r % cols_small);
    if (r < cols_small) r = cols_small;
    return r;
  endfunction

  // Three passes over every active tile, plus pipeline fill and a safety margin.
  function automatic int step_budget(input int res,
                                     input int rows_small = 4,
                                     input int cols_small = 4,
                                     input int margin     = 4);
    return 3 * (res / rows_small) * (res / cols_small) + 2 + margin;
  endfunction

endpackage

// File: rtl/sand_step_scheduler_arbiter.sv
// Round-robin arbiter for grain-drop sources.
//   clk, rst : clock, asynchronous active-high reset
//   req      : one request bit per source
//   advance  : consume the current grant (rotates the pointer if anything was granted)
//   grant    : one-hot grant, combinational from req and the rotating pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  int            idx;
  int            win;

  // Scan from the highest offset down so the source closest to ptr is the last
  // (and therefore winning) assignment.
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise paths that
    // skip an assignment would infer latches.
    grant = '0;
    idx   = 0;
    win   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= PW'((win + 1) % N);
    end
  end

endmodule

// File: rtl/sand_step_scheduler.sv
// Step scheduler for the tiled sandpile array.
// Decides when a relaxation step starts (free-run on a vsync divider or single
// step), arbitrates drop requests round-robin, and holds drop/coords/resolution
// stable for the whole step. The array has no busy flag, so each step lasts a
// computed cycle budget.
//   clk, rst       : clock, asynchronous active-high reset
//   vsync_i        : one-cycle pulse per video frame
//   run_i, step_i  : free-run enable / single-step request
//   speed_i        : free-run divides vsync by speed_i+1
//   cfg_res_i      : requested resolution
//   req_valid_i/x/y: drop requests, source i at bits [9i+8:9i]
//   req_ready_o    : one-hot accept, pulses in ISSUE
//   new_frame_o    : step start pulse
//   drop_o/x/y     : drop enable and coordinates, held through the step
//   resolution_o   : sanitised resolution, only updates in IDLE
//   busy_o         : step in flight (ISSUE, BUSY, DONE)
//   step_count_o   : steps issued, wrapping
module sand_step_scheduler
  import sand_ctrl_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int COLS       = 32,
  parameter int ROWS_SMALL = 4,
  parameter int COLS_SMALL = 4,
  parameter int NREQ       = 3,
  parameter int MARGIN     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_i,
  input  logic                    run_i,
  input  logic                    step_i,
  input  logic [3:0]              speed_i,
  input  logic [COORD_W-1:0]      cfg_res_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [COORD_W*NREQ-1:0] req_x_i,
  input  logic [COORD_W*NREQ-1:0] req_y_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    new_frame_o,
  output logic                    drop_o,
  output logic [COORD_W-1:0]      drop_x_o,
  output logic [COORD_W-1:0]      drop_y_o,
  output logic [COORD_W-1:0]      resolution_o,
  output logic                    busy_o,
  output logic [15:0]             step_count_o
);

  localparam int BUDGET_MAX = 3 * (ROWS / ROWS_SMALL) * (COLS / COLS_SMALL) + 3 + MARGIN;
  localparam int CNT_W      = $clog2(BUDGET_MAX);

  sched_state_t         state;
  logic [3:0]           div;
  logic                 pending;
  logic [CNT_W-1:0]     cnt;

  logic                 trigger;
  logic                 start;
  logic [NREQ-1:0]      grant;
  logic [COORD_W-1:0]   res_now;
  logic [CNT_W-1:0]     busy_load;
  logic [COORD_W-1:0]   win_x;
  logic [COORD_W-1:0]   win_y;
  logic                 win_valid;
  logic                 in_range;

  // The step is launched on the edge that enters ISSUE, so arbitration, the
  // resolution snapshot and the budget are all evaluated in that IDLE cycle and
  // every ISSUE output is a plain register.
  assign start     = (state == IDLE) && pending;
  // >= rather than == so lowering speed_i mid-count cannot strand the divider.
  assign trigger   = run_i ? (vsync_i && (div >= speed_i)) : step_i;
  assign res_now   = COORD_W'(sanitize_res(int'(cfg_res_i), ROWS, COLS, COLS_SMALL));
  // ISSUE and DONE account for two cycles of the budget; BUSY covers the rest.
  assign busy_load = CNT_W'(step_budget(int'(res_now), ROWS_SMALL, COLS_SMALL, MARGIN) - 2);
  assign win_valid = |grant;
  assign in_range  = (win_x < res_now) && (win_y < res_now);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid_i),
    .advance (start),
    .grant   (grant)
  );

  always_comb begin
    win_x = '0;
    win_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_x = req_x_i[COORD_W*i +: COORD_W];
        win_y = req_y_i[COORD_W*i +: COORD_W];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so each register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div          <= '0;
      pending      <= 1'b0;
      cnt          <= '0;
      req_ready_o  <= '0;
      new_frame_o  <= 1'b0;
      drop_o       <= 1'b0;
      drop_x_o     <= '0;
      drop_y_o     <= '0;
      resolution_o <= COORD_W'(ROWS);
      busy_o       <= 1'b0;
      step_count_o <= '0;
    end else begin
      new_frame_o <= 1'b0;
      req_ready_o <= '0;

      if (!run_i) begin
        div <= '0;
      end else if (vsync_i) begin
        div <= (div >= speed_i) ? 4'd0 : div + 4'd1;
      end

      // A new trigger wins over the clear so nothing arriving on the launch
      // edge is lost.
      if (trigger) begin
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          resolution_o <= res_now;
          if (pending) begin
            state        <= ISSUE;
            new_frame_o  <= 1'b1;
            busy_o       <= 1'b1;
            req_ready_o  <= grant;
            drop_o       <= win_valid && in_range;
            cnt          <= busy_load;
            step_count_o <= step_count_o + 16'd1;
            if (win_valid) begin
              drop_x_o <= win_x;
              drop_y_o <= win_y;
            end
          end
        end
        ISSUE: begin
          state <= BUSY;
        end
        BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          drop_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
